conv_seq_ctrl: RTL and testbench

//  Sequencer for the 1-D convolution engine: accepts the 2N-sample input frame
//  (x[0..N-1] then h[0..N-1], 4-bit each) over the Din/in_en/busy handshake,

---
 rtl/conv_seq_ctrl.sv | 155 +++++++++++++++
 tb/tb_conv_seq_ctrl.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_seq_ctrl.sv
// conv_seq_ctrl: sequencer for the 1-D convolution engine.
// It takes in a 2N-sample frame (x then h) and then issues the N*N products
// of the full convolution to the external MAC. Each y[k] is flagged on
// out_valid/out_idx.
// Optional feature: define CONV_CTRL_BACKPRESSURE_EN to add an out_ready port.
// While a result is held and out_ready is low, issuing stalls.
//
//  state  | meaning
//  S_LOAD | accepting samples, busy=0
//  S_CALC | one MAC issue per cycle, k outer / i inner
//  S_DONE | last result valid, frame_done pulse, back to S_LOAD
module conv_seq_ctrl #(
    parameter int N  = 8,
    parameter int AW = 3
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_en,
    output logic          busy,
    output logic          buf_we,
    output logic [AW:0]   buf_waddr,
    output logic [AW-1:0] mac_xaddr,
    output logic [AW-1:0] mac_haddr,
    output logic          mac_en,
    output logic          mac_clr,
    output logic          out_valid,
`ifdef CONV_CTRL_BACKPRESSURE_EN
    input  logic          out_ready,
`endif
    output logic [AW:0]   out_idx,
    output logic          frame_done
);

    localparam logic [AW:0]   LAST_LOAD = (AW+1)'(2*N-1);
    localparam logic [AW:0]   LAST_K    = (AW+1)'(2*N-2);
    localparam logic [AW:0]   N_M1      = (AW+1)'(N-1);
    localparam logic [AW-1:0] N_M1_S    = AW'(N-1);

    typedef enum logic [1:0] {
        S_LOAD = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [AW:0]   load_cnt_q, load_cnt_d;
    logic [AW:0]   k_q, k_d;
    logic [AW-1:0] i_q, i_d;
    logic          out_valid_q, out_valid_d;
    logic [AW:0]   out_idx_q, out_idx_d;
    logic          frame_done_q, frame_done_d;

    logic          stall;
    logic [AW:0]   k_next;
    logic [AW-1:0] lo_cur, hi_cur, lo_next;

`ifdef CONV_CTRL_BACKPRESSURE_EN
    assign stall = out_valid_q & ~out_ready;
`else
    assign stall = 1'b0;
`endif

    // The i range for the current k and the next k.
    // lo keeps k-i within 0..N-1, so the h index always fits AW bits.
    assign k_next  = k_q + 1'b1;
    assign lo_cur  = (k_q > N_M1) ? AW'(k_q - N_M1) : '0;
    assign hi_cur  = (k_q > N_M1) ? N_M1_S : k_q[AW-1:0];
    assign lo_next = (k_next > N_M1) ? AW'(k_next - N_M1) : '0;

    // Next-state logic, counter updates, and the MAC issue strobes.
    always_comb begin
        state_d      = state_q;
        load_cnt_d   = load_cnt_q;
        k_d          = k_q;
        i_d          = i_q;
        out_valid_d  = 1'b0;
        out_idx_d    = out_idx_q;
        frame_done_d = 1'b0;
        mac_en       = 1'b0;
        mac_clr      = 1'b0;
        if (stall) begin
            out_valid_d  = out_valid_q;
            frame_done_d = frame_done_q;
        end else begin
            case (state_q)
                S_LOAD: begin
                    if (in_en) begin
                        load_cnt_d = load_cnt_q + 1'b1;
                        if (load_cnt_q == LAST_LOAD) begin
                            load_cnt_d = '0;
                            state_d    = S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    mac_en  = 1'b1;
                    mac_clr = (i_q == lo_cur);
                    if (i_q == hi_cur) begin
                        out_valid_d = 1'b1;
                        out_idx_d   = k_q;
                        if (k_q == LAST_K) begin
                            state_d      = S_DONE;
                            frame_done_d = 1'b1;
                            k_d          = '0;
                            i_d          = '0;
                        end else begin
                            k_d = k_next;
                            i_d = lo_next;
                        end
                    end else begin
                        i_d = i_q + 1'b1;
                    end
                end
                S_DONE: begin
                    state_d = S_LOAD;
                end
                default: begin
                    state_d = S_LOAD;
                end
            endcase
        end
    end

    // State and counter registers.
    // An async reset drops any partial frame.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_LOAD;
            load_cnt_q   <= '0;
            k_q          <= '0;
            i_q          <= '0;
            out_valid_q  <= 1'b0;
            out_idx_q    <= '0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            load_cnt_q   <= load_cnt_d;
            k_q          <= k_d;
            i_q          <= i_d;
            out_valid_q  <= out_valid_d;
            out_idx_q    <= out_idx_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign busy       = (state_q != S_LOAD);
    assign buf_we     = in_en & ~busy;
    assign buf_waddr  = load_cnt_q;
    assign mac_xaddr  = i_q;
    assign mac_haddr  = AW'(k_q - {1'b0, i_q});
    assign out_valid  = out_valid_q;
    assign out_idx    = out_idx_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_conv_seq_ctrl.sv
// Bench for conv_seq_ctrl with N=8.
// For each frame, the expected MAC issues and results are queued and then
// drained as the DUT produces them.
// Define CONV_CTRL_BACKPRESSURE_EN to also exercise out_ready stalls.
module tb_conv_seq_ctrl;
    localparam int N  = 8;
    localparam int AW = 3;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          in_en = 1'b0;
    logic          out_ready = 1'b1;
    logic          busy, buf_we, mac_en, mac_clr, out_valid, frame_done;
    logic [AW:0]   buf_waddr, out_idx;
    logic [AW-1:0] mac_xaddr, mac_haddr;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int t0 = 0;
    int fd_cyc = 0;
    bit last_fd = 1'b0;
    int mac_cnt = 0;
    int ov_cnt = 0;
    int ov_cycles = 0;

    logic [6:0] exp_issue[$];
    logic [3:0] exp_out[$];

    conv_seq_ctrl #(.N(N), .AW(AW)) dut (
        .clk(clk),
        .reset(reset),
        .in_en(in_en),
        .busy(busy),
        .buf_we(buf_we),
        .buf_waddr(buf_waddr),
        .mac_xaddr(mac_xaddr),
        .mac_haddr(mac_haddr),
        .mac_en(mac_en),
        .mac_clr(mac_clr),
        .out_valid(out_valid),
`ifdef CONV_CTRL_BACKPRESSURE_EN
        .out_ready(out_ready),
`endif
        .out_idx(out_idx),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required normal completion");
        $fatal(1, "watchdog");
    end

    // Expected issues: every (i,j) pair with i+j=k, taken in increasing i.
    // The first pair of each k clears the accumulator.
    task automatic push_model();
        int j;
        bit first;
        for (int k = 0; k < 2*N-1; k++) begin
            first = 1'b1;
            for (int i = 0; i < N; i++) begin
                j = k - i;
                if (j >= 0 && j < N) begin
                    exp_issue.push_back({3'(i), 3'(j), first});
                    first = 1'b0;
                end
            end
            exp_out.push_back(4'(k));
        end
    endtask

    // One clock: drain the scoreboard at the negedge, then return 1 time unit after the posedge.
    task automatic tick();
        logic [6:0] e;
        logic [3:0] eo;
        @(negedge clk);
        last_fd = 1'b0;
        if (reset) begin
            if (mac_en) begin
                mac_cnt++;
                checks++;
                if (exp_issue.size() == 0) begin
                    errors++;
                    $display("FAIL issue_extra: got x=%0d h=%0d clr=%0d, required no issue", mac_xaddr, mac_haddr, mac_clr);
                end else begin
                    e = exp_issue.pop_front();
                    if ({mac_xaddr, mac_haddr, mac_clr} !== e) begin
                        errors++;
                        $display("FAIL issue: got x=%0d h=%0d clr=%0d, required x=%0d h=%0d clr=%0d",
                                 mac_xaddr, mac_haddr, mac_clr, e[6:4], e[3:1], e[0]);
                    end
                end
            end
            checks++;
            if (mac_clr === 1'b1 && mac_en !== 1'b1) begin
                errors++;
                $display("FAIL clr_without_en: got mac_clr=1 mac_en=%0b, required mac_clr=0", mac_en);
            end
            if (out_valid === 1'b1) begin
                ov_cycles++;
                if (frame_done === 1'b1) begin
                    last_fd = 1'b1;
                    fd_cyc  = cyc;
                end
                if (out_ready) begin
                    ov_cnt++;
                    checks++;
                    if (exp_out.size() == 0) begin
                        errors++;
                        $display("FAIL result_extra: got out_idx=%0d, required no result", out_idx);
                    end else begin
                        eo = exp_out.pop_front();
                        if (out_idx !== eo || frame_done !== (eo == 4'(2*N-2))) begin
                            errors++;
                            $display("FAIL result: got idx=%0d fd=%0b, required idx=%0d fd=%0b",
                                     out_idx, frame_done, eo, (eo == 4'(2*N-2)));
                        end
                    end
                end
            end else begin
                checks++;
                if (frame_done !== 1'b0) begin
                    errors++;
                    $display("FAIL fd_without_valid: got frame_done=%0b, required 0", frame_done);
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic load_frame(input bit gaps);
        push_model();
        mac_cnt = 0;
        ov_cnt = 0;
        ov_cycles = 0;
        for (int s = 0; s < 2*N; s++) begin
            if (gaps && s != 0) begin
                in_en = 1'b0;
                #1;
                checks++;
                if (buf_we !== 1'b0) begin
                    errors++;
                    $display("FAIL gap_we: got buf_we=%0b, required 0", buf_we);
                end
                tick();
            end
            in_en = 1'b1;
            #1;
            checks++;
            if (buf_we !== 1'b1 || buf_waddr !== 4'(s) || busy !== 1'b0) begin
                errors++;
                $display("FAIL load_s%0d: got we=%0b addr=%0d busy=%0b, required we=1 addr=%0d busy=0",
                         s, buf_we, buf_waddr, busy, s);
            end
            tick();
        end
        in_en = 1'b0;
        t0 = cyc;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL busy_rise: got busy=%0b, required 1", busy);
        end
    endtask

    task automatic wait_frame_end(input int exp_lat);
        int n;
        bit seen;
        n = 0;
        seen = 1'b0;
        while (!seen && n < 300) begin
            tick();
            n++;
            if (last_fd) seen = 1'b1;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL frame_timeout: got no frame_done in %0d cycles, required frame_done", n);
        end
        checks++;
        if (fd_cyc - t0 + 1 !== exp_lat) begin
            errors++;
            $display("FAIL latency: got %0d, required %0d", fd_cyc - t0 + 1, exp_lat);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL busy_fall: got busy=%0b, required 0", busy);
        end
        checks++;
        if (mac_cnt !== N*N || ov_cnt !== 2*N-1 || exp_issue.size() != 0 || exp_out.size() != 0) begin
            errors++;
            $display("FAIL frame_counts: got mac=%0d res=%0d left=%0d/%0d, required mac=%0d res=%0d left=0/0",
                     mac_cnt, ov_cnt, exp_issue.size(), exp_out.size(), N*N, 2*N-1);
        end
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if (busy !== 0 || buf_we !== 0 || buf_waddr !== 0 || mac_en !== 0 || mac_clr !== 0 ||
            out_valid !== 0 || out_idx !== 0 || frame_done !== 0 || mac_xaddr !== 0 || mac_haddr !== 0) begin
            errors++;
            $display("FAIL reset_state: got busy=%0b we=%0b wa=%0d en=%0b clr=%0b ov=%0b idx=%0d fd=%0b x=%0d h=%0d, required all 0",
                     busy, buf_we, buf_waddr, mac_en, mac_clr, out_valid, out_idx, frame_done, mac_xaddr, mac_haddr);
        end
        @(posedge clk);
        #1;
        reset = 1'b1;
        // A partial load followed by reset must restart from address 0.
        in_en = 1'b1;
        repeat (5) tick();
        in_en = 1'b0;
        reset = 1'b0;
        #1;
        checks++;
        if (busy !== 0 || buf_waddr !== 0 || mac_en !== 0 || out_valid !== 0) begin
            errors++;
            $display("FAIL reset_mid_load: got busy=%0b wa=%0d en=%0b ov=%0b, required 0/0/0/0",
                     busy, buf_waddr, mac_en, out_valid);
        end
        tick();
        reset = 1'b1;
        tick();
    endtask

    task automatic test_load_contiguous();
        load_frame(1'b0);
        in_en = 1'b1;
        #1;
        checks++;
        if (buf_we !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL extra_sample: got we=%0b busy=%0b, required we=0 busy=1", buf_we, busy);
        end
        in_en = 1'b0;
        wait_frame_end(N*N+1);
    endtask

    task automatic test_gaps_back_to_back();
        load_frame(1'b1);
        wait_frame_end(N*N+1);
        load_frame(1'b0);
        wait_frame_end(N*N+1);
    endtask

    task automatic test_reset_mid_calc();
        load_frame(1'b0);
        repeat (15) tick();
        checks++;
        if (mac_cnt !== 15 || ov_cnt !== 4) begin
            errors++;
            $display("FAIL pre_reset_counts: got mac=%0d res=%0d, required mac=15 res=4", mac_cnt, ov_cnt);
        end
        reset = 1'b0;
        #1;
        checks++;
        if (busy !== 0 || out_valid !== 0 || mac_en !== 0 || mac_clr !== 0 || frame_done !== 0) begin
            errors++;
            $display("FAIL reset_mid_calc: got busy=%0b ov=%0b en=%0b clr=%0b fd=%0b, required all 0",
                     busy, out_valid, mac_en, mac_clr, frame_done);
        end
        exp_issue.delete();
        exp_out.delete();
        tick();
        reset = 1'b1;
        tick();
        load_frame(1'b0);
        wait_frame_end(N*N+1);
    endtask

`ifdef CONV_CTRL_BACKPRESSURE_EN
    task automatic test_backpressure();
        load_frame(1'b0);
        repeat (10) tick();
        out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++;
            if (out_valid !== 1'b1 || out_idx !== 4'd3 || mac_en !== 1'b0) begin
                errors++;
                $display("FAIL stall_c%0d: got ov=%0b idx=%0d en=%0b, required ov=1 idx=3 en=0",
                         c, out_valid, out_idx, mac_en);
            end
            tick();
        end
        out_ready = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b1 || out_idx !== 4'd3 || mac_en !== 1'b1 || mac_clr !== 1'b1 ||
            mac_xaddr !== 3'd0 || mac_haddr !== 3'd4) begin
            errors++;
            $display("FAIL resume: got ov=%0b idx=%0d en=%0b clr=%0b x=%0d h=%0d, required 1/3/1/1/0/4",
                     out_valid, out_idx, mac_en, mac_clr, mac_xaddr, mac_haddr);
        end
        wait_frame_end(N*N+4);
        checks++;
        if (ov_cycles !== 2*N-1+3) begin
            errors++;
            $display("FAIL stall_valid_cycles: got %0d, required %0d", ov_cycles, 2*N-1+3);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_load_contiguous();
        test_gaps_back_to_back();
        test_reset_mid_calc();
`ifdef CONV_CTRL_BACKPRESSURE_EN
        test_backpressure();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
